// File: rtl/dmem_block_copy.sv
// Block copy / block fill engine that owns the single-port data memory port while busy.
// Copy takes three cycles per byte (read, capture, write); fill writes one byte per cycle.
module dmem_block_copy #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          op,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [7:0]    len,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_w,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, FILL, FIN} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] src_reg, src_next;
    logic [AW-1:0] dst_reg, dst_next;
    logic [7:0]    len_reg, len_next;
    logic [DW-1:0] fill_reg, fill_next;
    logic [7:0]    k_reg, k_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          mem_w_reg, mem_w_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [DW-1:0] mem_wdata_reg, mem_wdata_next;

    logic [7:0]    k_inc;
    logic          last_byte;

    assign k_inc     = k_reg + 8'd1;
    assign last_byte = (k_inc == len_reg);

    // Outputs are computed for the upcoming state and registered, so every
    // port value lines up with the state it belongs to.
    always_comb begin
        state_next     = state_reg;
        src_next       = src_reg;
        dst_next       = dst_reg;
        len_next       = len_reg;
        fill_next      = fill_reg;
        k_next         = k_reg;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        mem_w_next     = 1'b1;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    src_next  = src;
                    dst_next  = dst;
                    len_next  = len;
                    fill_next = fill_val;
                    k_next    = 8'd0;
                    if (len == 8'd0) begin
                        state_next = FIN;
                        done_next  = 1'b1;
                    end else if (!op) begin
                        state_next    = RD;
                        busy_next     = 1'b1;
                        mem_addr_next = src;
                    end else begin
                        state_next     = FILL;
                        busy_next      = 1'b1;
                        mem_w_next     = 1'b0;
                        mem_addr_next  = dst;
                        mem_wdata_next = fill_val;
                    end
                end
            end
            RD: begin
                state_next = CAP;
                busy_next  = 1'b1;
            end
            CAP: begin
                // Read data for the RD address is valid now; it becomes the write data.
                state_next     = WR;
                busy_next      = 1'b1;
                mem_w_next     = 1'b0;
                mem_addr_next  = dst_reg + AW'(k_reg);
                mem_wdata_next = mem_rdata;
            end
            WR: begin
                if (last_byte) begin
                    state_next = FIN;
                    done_next  = 1'b1;
                end else begin
                    state_next    = RD;
                    busy_next     = 1'b1;
                    k_next        = k_inc;
                    mem_addr_next = src_reg + AW'(k_inc);
                end
            end
            FILL: begin
                if (last_byte) begin
                    state_next = FIN;
                    done_next  = 1'b1;
                end else begin
                    busy_next      = 1'b1;
                    k_next         = k_inc;
                    mem_w_next     = 1'b0;
                    mem_addr_next  = dst_reg + AW'(k_inc);
                    mem_wdata_next = fill_reg;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            src_reg       <= '0;
            dst_reg       <= '0;
            len_reg       <= '0;
            fill_reg      <= '0;
            k_reg         <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            mem_w_reg     <= 1'b1;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            src_reg       <= src_next;
            dst_reg       <= dst_next;
            len_reg       <= len_next;
            fill_reg      <= fill_next;
            k_reg         <= k_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            mem_w_reg     <= mem_w_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign mem_w     = mem_w_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_block_copy.sv
// Bench for dmem_block_copy: a table of copy/fill commands against a behavioural
// memory, plus hand-written sequences for reset, restart and ignored-start cases.
module tb_dmem_block_copy;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] src = '0, dst = '0, len = '0, fill_val = '0;
    logic       busy, done, mem_w;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic [7:0] mem [256];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_block_copy #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src(src), .dst(dst),
        .len(len), .fill_val(fill_val), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w(mem_w),
        .mem_rdata(mem_rdata)
    );

    // Behavioural single-port memory with registered read.
    always @(posedge clk) begin
        if (mem_w === 1'b0) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        int op, src, dst, len, fill;
        int done_cyc, busy_cyc, nwr;
        int fw_cyc, fw_addr, fw_data;
        int lw_cyc, lw_addr, lw_data;
        int ca, cv, cb, cbv;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input int o, input int s, input int d, input int l, input int f);
        @(negedge clk);
        start = 1'b1; op = o[0]; src = s[7:0]; dst = d[7:0]; len = l[7:0]; fill_val = f[7:0];
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    vec_t vecs [5];

    initial begin
        int wr_cnt, busy_cnt, done_cyc, fw_cyc, fw_addr, fw_data, lw_cyc, lw_addr, lw_data;
        bit done_seen;

        for (int i = 0; i < 256; i++) mem[i] = i[7:0];

        vecs[0] = '{0, 2, 20, 4, 0,      13, 12, 4,  3, 20, 2,      12, 23, 5,      24, 24,      22, 4};
        vecs[1] = '{1, 0, 5, 3, 'hAA,    4, 3, 3,    1, 5, 'hAA,    3, 7, 'hAA,     4, 4,        8, 8};
        vecs[2] = '{0, 0, 40, 0, 0,      1, 0, 0,    0, 0, 0,       0, 0, 0,        40, 40,      41, 41};
        vecs[3] = '{1, 0, 254, 3, 'h55,  4, 3, 3,    1, 254, 'h55,  3, 0, 'h55,     255, 'h55,   1, 1};
        vecs[4] = '{0, 10, 11, 3, 0,     10, 9, 3,   3, 11, 10,     9, 13, 10,      12, 10,      14, 14};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_w", mem_w, 1);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst = 1'b0;

        // Reset in cycle 5 of a copy, with an extra start pulse while busy
        issue(0, 0, 16, 4, 0);
        wr_cnt = 0; done_seen = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_w === 1'b0) wr_cnt++;
            if (done === 1'b1) done_seen = 1;
            if (c == 6) begin
                check("rstmid_mem_w", mem_w, 1);
                check("rstmid_busy", busy, 0);
                check("rstmid_addr", mem_addr, 0);
                rst = 1'b0;
            end
            if (c == 2) begin
                start = 1'b1; op = 1'b1; dst = 8'd17; len = 8'd1; fill_val = 8'hEE;
            end
            if (c == 3) start = 1'b0;
            if (c == 5) rst = 1'b1;
        end
        check("rstmid_writes", wr_cnt, 1);
        check("rstmid_done", done_seen, 0);
        check("rstmid_mem16", mem[16], 0);
        check("rstmid_mem17", mem[17], 17);

        // Table-driven commands
        for (int v = 0; v < 5; v++) begin
            issue(vecs[v].op, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill);
            wr_cnt = 0; busy_cnt = 0; done_cyc = -1;
            fw_cyc = -1; fw_addr = -1; fw_data = -1; lw_cyc = -1; lw_addr = -1; lw_data = -1;
            for (int c = 1; c <= 1000; c++) begin
                @(negedge clk);
                if (mem_w === 1'b0) begin
                    if (wr_cnt == 0) begin fw_cyc = c; fw_addr = mem_addr; fw_data = mem_wdata; end
                    lw_cyc = c; lw_addr = mem_addr; lw_data = mem_wdata;
                    wr_cnt++;
                end
                if (busy === 1'b1) busy_cnt++;
                if (done === 1'b1) begin done_cyc = c; break; end
            end
            check($sformatf("v%0d_done_cyc", v), done_cyc, vecs[v].done_cyc);
            check($sformatf("v%0d_busy_cyc", v), busy_cnt, vecs[v].busy_cyc);
            check($sformatf("v%0d_nwr", v), wr_cnt, vecs[v].nwr);
            if (vecs[v].nwr > 0) begin
                check($sformatf("v%0d_fw_cyc", v), fw_cyc, vecs[v].fw_cyc);
                check($sformatf("v%0d_fw_addr", v), fw_addr, vecs[v].fw_addr);
                check($sformatf("v%0d_fw_data", v), fw_data, vecs[v].fw_data);
                check($sformatf("v%0d_lw_cyc", v), lw_cyc, vecs[v].lw_cyc);
                check($sformatf("v%0d_lw_addr", v), lw_addr, vecs[v].lw_addr);
                check($sformatf("v%0d_lw_data", v), lw_data, vecs[v].lw_data);
            end
            check($sformatf("v%0d_mem_a", v), mem[vecs[v].ca], vecs[v].cv);
            check($sformatf("v%0d_mem_b", v), mem[vecs[v].cb], vecs[v].cbv);
        end

        // Start held through busy and FIN is ignored, accepted the cycle after FIN
        issue(1, 0, 50, 1, 'h11);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            case (c)
                1: begin
                    check("fin_c1_mem_w", mem_w, 0);
                    check("fin_c1_addr", mem_addr, 50);
                    check("fin_c1_data", mem_wdata, 'h11);
                    start = 1'b1; op = 1'b1; dst = 8'd60; len = 8'd1; fill_val = 8'h22;
                end
                2: check("fin_c2_done", done, 1);
                3: begin
                    check("fin_c3_mem_w", mem_w, 1);
                    check("fin_c3_done", done, 0);
                    check("fin_c3_busy", busy, 0);
                end
                4: begin
                    start = 1'b0;
                    check("fin_c4_mem_w", mem_w, 0);
                    check("fin_c4_addr", mem_addr, 60);
                    check("fin_c4_data", mem_wdata, 'h22);
                end
                default: check("fin_c5_done", done, 1);
            endcase
        end

        // rst and start together: the command is dropped
        @(negedge clk);
        start = 1'b1; rst = 1'b1; op = 1'b1; dst = 8'd70; len = 8'd2; fill_val = 8'h33;
        @(posedge clk);
        #1 start = 1'b0; rst = 1'b0;
        wr_cnt = 0; busy_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (mem_w === 1'b0) wr_cnt++;
            if (busy === 1'b1 || done === 1'b1) busy_cnt++;
        end
        check("rststart_writes", wr_cnt, 0);
        check("rststart_activity", busy_cnt, 0);
        check("rststart_mem70", mem[70], 70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
